fwd_track_unit: RTL and testbench

- Parametrised successor to the EXE-stage forwarding block.
- Keeps its own shift-register record of in-flight writers (dest, write-enable, load flag) for DEPTH post-EXE stages, instead of taking MEM/WB dest ports.
- Produces one forwarding select per source operand and a load-use stall request.
- Sits beside the EXE stage; the EXE operand muxes consume the selects, and the stall drives the IF/ID/EXE freeze logic.

---
 rtl/fwd_track_unit.sv | 107 ++++++++++
 tb/tb_fwd_track_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_track_unit.sv
// fwd_track_unit: EXE-stage forwarding and load-use hazard unit.
// Keeps its own shift-register record of the writers that have left EXE
// (DEPTH stages deep). From that record it produces one forwarding select
// per source operand and a single stall request for the front of the pipe.
module fwd_track_unit #(
   parameter int REG_W      = 5,
   parameter int NUM_SRC    = 3,
   parameter int DEPTH      = 2,
   parameter int LOAD_READY = 2,
   parameter int SEL_SIZE   = 3,
   parameter int CNT_W      = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        freeze,
   input  logic                        flush,
   input  logic                        fwd_en,
   input  logic [REG_W-1:0]            exe_dest,
   input  logic                        exe_wb_en,
   input  logic                        exe_mem_r_en,
   input  logic [NUM_SRC*REG_W-1:0]    src_exe,
   input  logic [NUM_SRC-1:0]          src_valid,
   output logic [NUM_SRC*SEL_SIZE-1:0] sel,
   output logic                        hazard_stall,
   output logic [CNT_W-1:0]            stall_cnt
);

   localparam logic [SEL_SIZE-1:0] LOAD_READY_S = SEL_SIZE'(LOAD_READY);
   localparam logic [CNT_W-1:0]    CNT_MAX      = '1;

   // Tracker entries, index 1 is the stage right after EXE (MEM).
   logic [DEPTH:1]       st_v;
   logic [DEPTH:1]       st_ld;
   logic [REG_W-1:0]     st_dest [DEPTH:1];

   logic [REG_W-1:0]     src_op    [NUM_SRC];
   logic [SEL_SIZE-1:0]  match_idx [NUM_SRC];
   logic [NUM_SRC-1:0]   match_ld;
   logic [NUM_SRC-1:0]   op_stall;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      assign src_op[g] = src_exe[g*REG_W +: REG_W];
   end

   // Find the youngest tracked writer of each operand; scanning from the
   // oldest stage down lets the youngest match overwrite older ones.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         match_idx[i] = '0;
         match_ld[i]  = 1'b0;
         for (int k = DEPTH; k >= 1; k--) begin
            if (src_valid[i] && st_v[k] && (st_dest[k] == src_op[i]) &&
                (src_op[i] != '0)) begin
               match_idx[i] = SEL_SIZE'(k);
               match_ld[i]  = st_ld[k];
            end
         end
      end
   end

   // Turn each match into a select or a stall. A load still short of the
   // stage where its data appears cannot be forwarded yet; in stall-only
   // mode any in-flight writer forces a wait for the register file.
   always_comb begin
      sel      = '0;
      op_stall = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (match_idx[i] != '0) begin
            if (!fwd_en) begin
               op_stall[i] = 1'b1;
            end else if (match_ld[i] && (match_idx[i] < LOAD_READY_S)) begin
               op_stall[i] = 1'b1;
            end else begin
               sel[i*SEL_SIZE +: SEL_SIZE] = match_idx[i];
            end
         end
      end
   end

   assign hazard_stall = |op_stall;

   // Shift the writer record one stage per unfrozen cycle; a stalled or
   // flushed EXE instruction enters as a bubble. Also count stall cycles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         st_v      <= '0;
         st_ld     <= '0;
         for (int k = 1; k <= DEPTH; k++) begin
            st_dest[k] <= '0;
         end
         stall_cnt <= '0;
      end else if (!freeze) begin
         for (int k = 2; k <= DEPTH; k++) begin
            st_v[k]    <= st_v[k-1];
            st_ld[k]   <= st_ld[k-1];
            st_dest[k] <= st_dest[k-1];
         end
         st_v[1]    <= exe_wb_en & ~flush & ~hazard_stall;
         st_ld[1]   <= exe_mem_r_en;
         st_dest[1] <= exe_dest;
         if (hazard_stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fwd_track_unit.sv
// tb_fwd_track_unit: drives two instances of fwd_track_unit (default
// parameters, and DEPTH=3 / LOAD_READY=3 / CNT_W=2) with the same inputs
// and compares them every cycle against a history-queue model, plus a set
// of hand-worked scenarios with literal expected values.
module tb_fwd_track_unit;

   logic        clk;
   logic        rst;
   logic        freeze;
   logic        flush;
   logic        fwd_en;
   logic [4:0]  exe_dest;
   logic        exe_wb_en;
   logic        exe_mem_r_en;
   logic [14:0] src_exe;
   logic [2:0]  src_valid;

   logic [8:0]  sel_a;
   logic        stall_a;
   logic [15:0] cnt_a;
   logic [8:0]  sel_b;
   logic        stall_b;
   logic [1:0]  cnt_b;

   int n_cmp  = 0;
   int n_fail = 0;

   fwd_track_unit dut_a (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .fwd_en(fwd_en),
      .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
      .src_exe(src_exe), .src_valid(src_valid),
      .sel(sel_a), .hazard_stall(stall_a), .stall_cnt(cnt_a)
   );

   fwd_track_unit #(.DEPTH(3), .LOAD_READY(3), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .fwd_en(fwd_en),
      .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
      .src_exe(src_exe), .src_valid(src_valid),
      .sel(sel_b), .hazard_stall(stall_b), .stall_cnt(cnt_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: for each instance, the last DEPTH instructions that left EXE,
   // youngest first (queue index 0 = one stage after EXE).
   typedef struct packed {
      logic       v;
      logic [4:0] dest;
      logic       ld;
   } wr_t;

   wr_t         hist_a[$];
   wr_t         hist_b[$];
   int unsigned mcnt_a = 0;
   int unsigned mcnt_b = 0;
   bit          model_ready = 1'b0;

   function automatic wr_t get_entry(input int inst, input int idx);
      if (inst == 0) return hist_a[idx];
      return hist_b[idx];
   endfunction

   // Expected selects and stall for one instance from the current inputs.
   function automatic void model_eval(input int inst, output logic [8:0] s,
                                      output logic stl);
      int         depth;
      int         lr;
      int         m;
      logic [4:0] src;
      wr_t        e;
      depth = (inst == 0) ? 2 : 3;
      lr    = (inst == 0) ? 2 : 3;
      s     = '0;
      stl   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         src = src_exe[i*5 +: 5];
         m   = 0;
         for (int k = 1; k <= depth; k++) begin
            e = get_entry(inst, k - 1);
            if (src_valid[i] && e.v && e.dest == src && src != 5'd0) begin
               m = k;
               break;
            end
         end
         if (m != 0) begin
            e = get_entry(inst, m - 1);
            if (!fwd_en) stl = 1'b1;
            else if (e.ld && m < lr) stl = 1'b1;
            else s[i*3 +: 3] = 3'(m);
         end
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model on every clock edge.
   always @(posedge clk) begin
      logic [8:0] ds;
      logic       sa;
      logic       sb;
      wr_t        ne;
      if (!rst) begin
         hist_a = {};
         hist_b = {};
         repeat (2) hist_a.push_back('0);
         repeat (3) hist_b.push_back('0);
         mcnt_a = 0;
         mcnt_b = 0;
         model_ready = 1'b1;
      end else if (model_ready && !freeze) begin
         model_eval(0, ds, sa);
         model_eval(1, ds, sb);
         ne.dest = exe_dest;
         ne.ld   = exe_mem_r_en;
         ne.v    = exe_wb_en & ~flush & ~sa;
         hist_a.push_front(ne);
         void'(hist_a.pop_back());
         ne.v    = exe_wb_en & ~flush & ~sb;
         hist_b.push_front(ne);
         void'(hist_b.pop_back());
         if (sa && mcnt_a < 65535) mcnt_a++;
         if (sb && mcnt_b < 3) mcnt_b++;
      end
   end

   // Compare both instances against the model mid-cycle.
   always @(negedge clk) begin
      logic [8:0] es;
      logic       est;
      if (model_ready) begin
         model_eval(0, es, est);
         check("model_sel_a", 32'(sel_a), 32'(es));
         check("model_stall_a", 32'(stall_a), 32'(est));
         check("model_cnt_a", 32'(cnt_a), mcnt_a);
         model_eval(1, es, est);
         check("model_sel_b", 32'(sel_b), 32'(es));
         check("model_stall_b", 32'(stall_b), 32'(est));
         check("model_cnt_b", 32'(cnt_b), mcnt_b);
      end
   end

   // Drive one cycle of inputs just after the edge, then let them settle.
   task automatic applyStimulus(input logic rs, input logic fz, input logic fl,
                                input logic fe, input logic [4:0] d,
                                input logic w, input logic l,
                                input logic [4:0] s0, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [2:0] v);
      @(posedge clk);
      #1;
      rst          = rs;
      freeze       = fz;
      flush        = fl;
      fwd_en       = fe;
      exe_dest     = d;
      exe_wb_en    = w;
      exe_mem_r_en = l;
      src_exe      = {s2, s1, s0};
      src_valid    = v;
      #3;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      check(name, act, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'b000);
   endtask

   initial begin
      rst = 1'b0; freeze = 1'b0; flush = 1'b0; fwd_en = 1'b1;
      exe_dest = '0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
      src_exe = '0; src_valid = '0;

      // Reset state
      repeat (2) applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'b000);
      idle(1);
      checkOutput("reset_sel", 32'(sel_a), 0);
      checkOutput("reset_stall", 32'(stall_a), 0);
      checkOutput("reset_cnt_a", 32'(cnt_a), 0);
      checkOutput("reset_cnt_b", 32'(cnt_b), 0);

      // Back-to-back ALU dependency on r5
      applyStimulus(1, 0, 0, 1, 5, 1, 0, 0, 0, 0, 3'b000);
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 5, 0, 0, 3'b001);
      checkOutput("alu_sel0_stage1", 32'(sel_a[2:0]), 1);
      checkOutput("alu_stall1", 32'(stall_a), 0);
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 5, 0, 0, 3'b001);
      checkOutput("alu_sel0_stage2", 32'(sel_a[2:0]), 2);
      checkOutput("alu_stall2", 32'(stall_a), 0);
      idle(3);

      // Load-use on r7 through src1
      applyStimulus(1, 0, 0, 1, 7, 1, 1, 0, 0, 0, 3'b000);
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 7, 0, 3'b010);
      checkOutput("ld_stall", 32'(stall_a), 1);
      checkOutput("ld_sel1_stalled", 32'(sel_a[5:3]), 0);
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 7, 0, 3'b010);
      checkOutput("ld_sel1_fwd", 32'(sel_a[5:3]), 2);
      checkOutput("ld_stall_done", 32'(stall_a), 0);
      checkOutput("ld_cnt", 32'(cnt_a), 1);
      idle(3);

      // Youngest writer wins; two operands may share a stage
      applyStimulus(1, 0, 0, 1, 3, 1, 0, 0, 0, 0, 3'b000);
      applyStimulus(1, 0, 0, 1, 3, 1, 0, 0, 0, 0, 3'b000);
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 3, 3, 0, 3'b011);
      checkOutput("prio_sel0", 32'(sel_a[2:0]), 1);
      checkOutput("prio_sel1", 32'(sel_a[5:3]), 1);
      checkOutput("prio_sel0_b", 32'(sel_b[2:0]), 1);
      idle(3);

      // Register 0 never forwards
      applyStimulus(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 3'b000);
      applyStimulus(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 3'b000);
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'b001);
      checkOutput("r0_sel0", 32'(sel_a[2:0]), 0);
      checkOutput("r0_stall", 32'(stall_a), 0);
      idle(3);

      // Freeze holds the tracker, then a flushed writer becomes a bubble
      applyStimulus(1, 0, 0, 1, 9, 1, 0, 0, 0, 0, 3'b000);
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1, 1, 0, 1, 0, 0, 0, 9, 0, 0, 3'b001);
         checkOutput("frz_sel0", 32'(sel_a[2:0]), 1);
         checkOutput("frz_cnt", 32'(cnt_a), 1);
      end
      applyStimulus(1, 0, 1, 1, 11, 1, 0, 0, 0, 0, 3'b000);
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 11, 9, 0, 3'b011);
      checkOutput("flush_sel0", 32'(sel_a[2:0]), 0);
      checkOutput("flush_sel1", 32'(sel_a[5:3]), 2);
      idle(3);

      // Stall-only mode
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
      applyStimulus(1, 0, 0, 0, 4, 1, 0, 0, 0, 0, 3'b000);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 4, 0, 0, 3'b001);
      checkOutput("so_stall1", 32'(stall_a), 1);
      checkOutput("so_sel1", 32'(sel_a), 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 4, 0, 0, 3'b001);
      checkOutput("so_stall2", 32'(stall_a), 1);
      checkOutput("so_sel2", 32'(sel_a), 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 4, 0, 0, 3'b001);
      checkOutput("so_stall3", 32'(stall_a), 0);
      checkOutput("so_cnt", 32'(cnt_a), 2);
      idle(3);

      // Deeper instance: load-use stalls twice, counter saturates at 3
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'b000);
      applyStimulus(1, 0, 0, 1, 7, 1, 1, 0, 0, 0, 3'b000);
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 7, 0, 3'b010);
      checkOutput("deep_stall1", 32'(stall_b), 1);
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 7, 0, 3'b010);
      checkOutput("deep_stall2", 32'(stall_b), 1);
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 7, 0, 3'b010);
      checkOutput("deep_stall3", 32'(stall_b), 0);
      checkOutput("deep_sel1", 32'(sel_b[5:3]), 3);
      checkOutput("deep_cnt", 32'(cnt_b), 2);
      for (int r = 0; r < 2; r++) begin
         applyStimulus(1, 0, 0, 1, 8, 1, 1, 0, 0, 0, 3'b000);
         repeat (3) applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 8, 0, 3'b010);
      end
      checkOutput("deep_cnt_sat", 32'(cnt_b), 3);
      idle(3);

      // Reset in the middle of a load-use stall
      applyStimulus(1, 0, 0, 1, 7, 1, 1, 0, 0, 0, 3'b000);
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 7, 0, 3'b010);
      checkOutput("rstmid_stall", 32'(stall_a), 1);
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 7, 0, 3'b010);
      checkOutput("rstmid_stall_after", 32'(stall_a), 0);
      checkOutput("rstmid_sel", 32'(sel_a), 0);
      checkOutput("rstmid_cnt", 32'(cnt_a), 0);

      // Randomised traffic over a small register set to provoke hazards
      begin
         logic fe;
         fe = 1'b1;
         for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(49) == 0) fe = ~fe;
            applyStimulus($urandom_range(99) != 0, $urandom_range(9) == 0,
                          $urandom_range(9) == 0, fe,
                          5'($urandom_range(7)), 1'($urandom),
                          $urandom_range(2) == 0,
                          5'($urandom_range(7)), 5'($urandom_range(7)),
                          5'($urandom_range(7)), 3'($urandom));
         end
      end
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
